rx_frame_parser: RTL



---
 rtl/rx_frame_parser_if.sv | 25 ++
 rtl/rx_frame_parser.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rx_frame_parser_if.sv
// Byte-in / word-out bus of the frame parser.
// The slave side is the parser. The master side is whoever feeds it bytes
// and consumes the committed words.
interface rx_frame_parser_if;
  logic [7:0]  rx_byte;
  logic        rx_strobe;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] frame_seq;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  err_code;
  logic        busy;

  modport slave (
    input  rx_byte, rx_strobe, word_ready,
    output word_data, word_valid, frame_seq, frame_done, frame_err, err_code, busy
  );

  modport master (
    output rx_byte, rx_strobe, word_ready,
    input  word_data, word_valid, frame_seq, frame_done, frame_err, err_code, busy
  );
endinterface

// File: rtl/rx_frame_parser.sv
// Frame parser: L, 2L data bytes, SEQ, CK.
// Payload words are staged speculatively in a word FIFO and become visible
// to the consumer only after the frame checksum verifies.
module rx_frame_parser #(
  parameter int DEPTH          = 32,
  parameter int MAX_WORDS      = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic          clock,
  input logic          reset,
  rx_frame_parser_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA_HI, S_DATA_LO, S_SEQ_HI, S_SEQ_LO, S_CK_HI, S_CK_LO, S_FINISH
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      cnt;
  logic [7:0]      hi_byte;
  logic [7:0]      ck_hi, ck_lo;
  logic [15:0]     seq;
  logic [15:0]     sum;
  logic            bad;
  logic [2:0]      bad_code;
  logic [TW-1:0]   tmo_cnt;
  logic [PW-1:0]   wr_spec, wr_commit, rd;
  logic [15:0]     mem [DEPTH];
  logic [15:0]     frame_seq_q;
  logic [2:0]      err_code_q;

  logic          active, tmo_fire, byte_take, fin, good, ck_ok;
  logic          full, do_write, ovf, pop, word_valid;
  logic [PW-1:0] occ;

  // The timeout counter only runs while a frame is being collected.
  assign active    = (state != S_IDLE) && (state != S_FINISH);
  assign tmo_fire  = active && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  // Bytes are dropped during FINISH and in the cycle the timeout fires.
  assign byte_take = bus.rx_strobe && !tmo_fire && (state != S_FINISH);
  assign fin       = (state == S_FINISH);
  assign ck_ok     = (sum == {ck_hi, ck_lo});
  assign good      = !bad && ck_ok;

  // Occupancy uses the pre-pop read pointer, so a same-cycle pop never
  // rescues a write; overflow is judged conservatively.
  assign occ      = wr_spec - rd;
  assign full     = (occ == PW'(DEPTH));
  assign do_write = byte_take && (state == S_DATA_LO) && !bad && !full;
  assign ovf      = byte_take && (state == S_DATA_LO) && !bad && full;

  assign word_valid = (wr_commit != rd);
  assign pop        = word_valid && bus.word_ready;

  assign bus.word_valid = word_valid;
  assign bus.word_data  = word_valid ? mem[rd[AW-1:0]] : 16'h0000;
  assign bus.frame_seq  = frame_seq_q;
  assign bus.err_code   = err_code_q;
  assign bus.frame_done = fin && good;
  assign bus.frame_err  = (fin && !good) || tmo_fire;
  assign bus.busy       = (state != S_IDLE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: walk the frame fields one accepted byte at a time.
  always_comb begin
    state_nxt = state;
    if (tmo_fire) begin
      state_nxt = S_IDLE;
    end else if (fin) begin
      state_nxt = S_IDLE;
    end else if (byte_take) begin
      case (state)
        S_IDLE:    state_nxt = (bus.rx_byte == 8'h00) ? S_SEQ_HI : S_DATA_HI;
        S_DATA_HI: state_nxt = S_DATA_LO;
        S_DATA_LO: state_nxt = (cnt == 8'd1) ? S_SEQ_HI : S_DATA_HI;
        S_SEQ_HI:  state_nxt = S_SEQ_LO;
        S_SEQ_LO:  state_nxt = S_CK_HI;
        S_CK_HI:   state_nxt = S_CK_LO;
        S_CK_LO:   state_nxt = S_FINISH;
        default:   state_nxt = state;
      endcase
    end
  end

  // Inter-byte gap counter; restarts on every strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        tmo_cnt <= '0;
    else if (!active || bus.rx_strobe) tmo_cnt <= '0;
    else                              tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Field capture, running checksum and the first-cause-wins bad flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      hi_byte  <= '0;
      ck_hi    <= '0;
      ck_lo    <= '0;
      seq      <= '0;
      sum      <= '0;
      bad      <= 1'b0;
      bad_code <= '0;
    end else if (byte_take) begin
      case (state)
        S_IDLE: begin
          cnt      <= bus.rx_byte;
          sum      <= {8'h00, bus.rx_byte};
          bad      <= (int'(bus.rx_byte) > MAX_WORDS);
          bad_code <= (int'(bus.rx_byte) > MAX_WORDS) ? 3'b010 : 3'b000;
        end
        S_DATA_HI: begin
          hi_byte <= bus.rx_byte;
          sum     <= sum + {8'h00, bus.rx_byte};
        end
        S_DATA_LO: begin
          sum <= sum + {8'h00, bus.rx_byte};
          cnt <= cnt - 8'd1;
          if (ovf) begin
            bad      <= 1'b1;
            bad_code <= 3'b011;
          end
        end
        S_SEQ_HI: begin
          seq[15:8] <= bus.rx_byte;
          sum       <= sum + {8'h00, bus.rx_byte};
        end
        S_SEQ_LO: begin
          seq[7:0] <= bus.rx_byte;
          sum      <= sum + {8'h00, bus.rx_byte};
        end
        S_CK_HI: ck_hi <= bus.rx_byte;
        S_CK_LO: ck_lo <= bus.rx_byte;
        default: ;
      endcase
    end
  end

  // FIFO pointers: speculative write, commit on a good FINISH, roll back
  // on a drop or timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_spec   <= '0;
      wr_commit <= '0;
      rd        <= '0;
    end else begin
      if (tmo_fire || (fin && !good)) wr_spec <= wr_commit;
      else if (do_write)              wr_spec <= wr_spec + 1'b1;
      if (fin && good) wr_commit <= wr_spec;
      if (pop)         rd        <= rd + 1'b1;
    end
  end

  // Held frame status: sequence of last good frame, cause of last drop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_seq_q <= '0;
      err_code_q  <= '0;
    end else begin
      if (fin && good)       frame_seq_q <= seq;
      if (tmo_fire)          err_code_q  <= 3'b100;
      else if (fin && !good) err_code_q  <= bad ? bad_code : 3'b001;
    end
  end

  // Word storage; contents are don't-care until committed, so no reset.
  always_ff @(posedge clock) begin
    if (do_write) mem[wr_spec[AW-1:0]] <= {hi_byte, bus.rx_byte};
  end
endmodule
